m65c02_mcyc_ctrl: RTL
=====================

Name: m65c02_mcyc_ctrl

Overview:
- Microcycle controller for the M65C02A microprogram sequencer.
- Generates the sequencer's `Rdy` clock enable, so each microcycle can last 1, 2 or 4 clocks, set by a microword length field.
- Stretches the final clock while an external memory/IO `Wait` is asserted, bounded by a timeout.
- Supports a debug `Halt` taken only at microcycle boundaries.
- Sits between the microword pipeline register, the memory interface and the sequencer `Rdy` input.

Parameters:
- pWaitMax, 15: maximum wait-extension clocks before `Rdy` is forced (1..255).
- pWCntW, 8: width of the wait counter; must satisfy 2^pWCntW > pWaitMax.

Ports:
- Clk  in  1  module clock
- Rst  in  1  reset, synchronous, active-high
- Len  in  2  microcycle length code from microword; valid in Start cycle
  - 0 = 1 clk
  - 1 = 2 clk
  - 2 = 4 clk
  - 3 = 4 clk with Wait sampling enabled
- Wait  in  1  external not-ready; honoured only when Len==3
- Halt  in  1  debug halt request
- Rdy  out  1  sequencer clock enable; high in last clock of a microcycle
- Start  out  1  high in first clock of a microcycle
- MC  out  2  remaining clocks in current microcycle (0 = last)
- WaitTO  out  1  one-clock pulse when a wait extension times out
- Halted  out  1  controller is in HALT state

Behaviour:
- Reset: Rst=1 at a clock edge gives state RST.
  - Next-cycle values: Rdy=0, Start=0, MC=0, WaitTO=0, Halted=0; Cnt, WCnt and captured Len cleared.
  - Rst applies mid-microcycle or mid-wait with no completion.
- States: RST, RUN, HALT (encoded in package).
- RST: held while Rst=1. The first clock after Rst falls is still RST (matches the sequencer's one-clock internal reset stretch). The next clock enters RUN with Start=1.
- RUN, Start cycle:
  - Rem = LenDec(Len) - 1, where LenDec gives 1, 2, 4, 4.
  - LenW <= (Len==3) is captured for the whole microcycle.
  - Cnt <= Rem-1 if Rem != 0.
- RUN, later cycles: Rem = Cnt, and Cnt decrements each clock while Rem != 0.
- MC = Rem in RUN, 0 otherwise (combinational).
- Last clock (Rem==0):
  - Stall = LenW & Wait & (WCnt != pWaitMax).
  - Rdy = ~Stall.
  - If Stall: stay at Rem==0 and WCnt++.
  - If LenW & Wait & (WCnt == pWaitMax): Rdy=1 and WaitTO=1 for one clock.
  - WCnt clears on every Rdy.
- For Len==3 in the Start cycle, the decoded length applies first. Wait is ignored until Rem==0.
- Latency:
  - Rdy is combinational from Wait and registered state only. There is no combinational path from Len to Rdy except Len==0, where the Start cycle is also the Rdy cycle.
  - Back-to-back microcycles: the clock after Rdy is a Start clock. There is no dead cycle.
- Halt:
  - Sampled only in a Rdy clock. If Halt=1 there, the next state is HALT.
  - In HALT: Rdy=0, Start=0, Halted=1.
  - The clock after Halt is seen low in HALT is a Start clock in RUN.
  - Halt asserted mid-microcycle or during a wait takes effect at that microcycle's Rdy. The in-flight microcycle always completes.
- Simultaneous events:
  - Rst overrides all.
  - A timeout and Halt in the same Rdy clock: WaitTO pulses and HALT is entered.
  - Wait with Len!=3 is ignored entirely.
- Invariant: exactly one Rdy per Start. Rdy never asserts in RST or HALT.

Decomposition:
- Package m65c02_mcyc_pkg:
  - state encodings (pSt_RST, pSt_RUN, pSt_HALT)
  - Len code constants (pLen1, pLen2, pLen4, pLen4W)
  - LenDec function
- One sub-module, m65c02_wait_tmr, containing WCnt with clear, increment and terminal-count compare. It outputs AtMax and is parameterised by pWaitMax and pWCntW.
- All remaining logic lives in the top level.

Test Plan:
- Reset release: Rst high for 3 clocks then low, with Len=0 → clock+1 is RST (Rdy=0). From clock+2 Start=1 and Rdy=1 every clock.
- Length sequence: Len=1,2,0 on successive Start cycles → Rdy after 2, 4 and 1 clocks respectively. MC=1,0 then 3,2,1,0 then 0. Start coincides with Rdy only for Len=0.
- Wait extension: Len=3, Wait=1 for 3 clocks from MC==0 then low → microcycle lasts 7 clocks, WaitTO=0. Len=2 with Wait=1 throughout → 4 clocks, no stretch.
- Timeout: pWaitMax=15, Len=3, Wait stuck high → Rdy and WaitTO both high on the 16th clock at MC==0 (microcycle of 19 clocks). The next microcycle starts normally with WCnt=0.
- Halt: Halt raised at MC==2 of a Len=2 microcycle → microcycle still ends with Rdy. Halted=1 from the next clock with Rdy=0. Halt dropped → one clock later Start=1, Halted=0.
- Reset mid-wait: Rst pulsed while stalled in Wait with WCnt=5 → RST state, WaitTO never pulses, and the first post-reset microcycle has WCnt=0.

Source files
------------

// File: rtl/m65c02_mcyc_pkg.sv
// m65c02_mcyc_pkg: state encodings, length codes and length decode for the microcycle controller
package m65c02_mcyc_pkg;
  typedef enum logic [1:0] {
    pSt_RST  = 2'd0,
    pSt_RUN  = 2'd1,
    pSt_HALT = 2'd2
  } state_t;
  localparam logic [1:0] pLen1  = 2'd0;
  localparam logic [1:0] pLen2  = 2'd1;
  localparam logic [1:0] pLen4  = 2'd2;
  localparam logic [1:0] pLen4W = 2'd3;
  function automatic logic [2:0] LenDec(input logic [1:0] len);
    return (len == pLen1) ? 3'd1 : (len == pLen2) ? 3'd2 : (len == pLen4 || len == pLen4W) ? 3'd4 : 3'd4;
  endfunction
endpackage

// File: rtl/m65c02_wait_tmr.sv
// m65c02_wait_tmr: wait-extension counter with clear, increment and terminal-count flag
module m65c02_wait_tmr #(
  parameter int pWaitMax = 15,
  parameter int pWCntW   = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  input  logic Inc,
  output logic AtMax
);
  logic [pWCntW-1:0] wcnt_q, wcnt_d;
  // clear on reset or microcycle completion, count stretched clocks otherwise
  always_comb wcnt_d = (Rst | Clr) ? '0 : Inc ? wcnt_q + pWCntW'(1) : wcnt_q;
  // counter register
  always_ff @(posedge Clk) wcnt_q <= wcnt_d;
  assign AtMax = (wcnt_q == pWCntW'(pWaitMax));
endmodule

// File: rtl/m65c02_mcyc_ctrl.sv
// m65c02_mcyc_ctrl: microcycle length, wait stretch and halt control generating sequencer Rdy
module m65c02_mcyc_ctrl
  import m65c02_mcyc_pkg::*;
#(
  parameter int pWaitMax = 15,
  parameter int pWCntW   = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Len,
  input  logic       Wait,
  input  logic       Halt,
  output logic       Rdy,
  output logic       Start,
  output logic [1:0] MC,
  output logic       WaitTO,
  output logic       Halted
);
  state_t     state_q, state_d;
  logic       first_q, first_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lenw_q, lenw_d;
  logic       run, lenw, last, stall, at_max;
  logic [1:0] rem;
  m65c02_wait_tmr #(.pWaitMax(pWaitMax), .pWCntW(pWCntW)) u_wait_tmr (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (Rdy),
    .Inc  (stall),
    .AtMax(at_max)
  );
  // outputs: remaining-clock count, last-clock stretch decision and status flags
  always_comb begin
    run    = (state_q == pSt_RUN);
    rem    = !run ? 2'd0 : first_q ? 2'(LenDec(Len) - 3'd1) : cnt_q;
    lenw   = first_q ? (Len == pLen4W) : lenw_q;
    last   = run & (rem == 2'd0);
    stall  = last & lenw & Wait & ~at_max;
    Rdy    = last & ~stall;
    WaitTO = last & lenw & Wait & at_max;
    Start  = run & first_q;
    MC     = rem;
    Halted = (state_q == pSt_HALT);
  end
  // next state: reset stretch, microcycle sequencing and halt at Rdy boundaries
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    lenw_d  = lenw_q;
    if (Rst) begin
      state_d = pSt_RST;
      first_d = 1'b0;
      cnt_d   = 2'd0;
      lenw_d  = 1'b0;
    end else begin
      unique case (state_q)
        pSt_RUN: begin
          lenw_d  = lenw;
          cnt_d   = (rem != 2'd0) ? 2'(rem - 2'd1) : cnt_q;
          first_d = Rdy;
          state_d = (Rdy & Halt) ? pSt_HALT : pSt_RUN;
        end
        pSt_HALT: begin
          state_d = Halt ? pSt_HALT : pSt_RUN;
          first_d = ~Halt;
        end
        default: begin
          state_d = pSt_RUN;
          first_d = 1'b1;
        end
      endcase
    end
  end
  // state register
  always_ff @(posedge Clk) begin
    state_q <= state_d;
    first_q <= first_d;
    cnt_q   <= cnt_d;
    lenw_q  <= lenw_d;
  end
endmodule
